startseq: RTL and testbench

Start sequencer placed directly upstream of the busy counter. Accepts tagged job requests over a valid/ready handshake and queues them in a small FIFO. Issues single-cycle start pulses to the busy counter only while it is idle, then tracks each job until the counter's busy output falls. Reports the active tag, and emits a done pulse carrying the completed job's tag.

---
 rtl/startseq_pkg.sv | 11 +
 rtl/startseq_fifo.sv | 46 ++++
 rtl/startseq.sv | 92 +++++++++
 tb/tb_startseq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/startseq_pkg.sv
// startseq_pkg: shared state encoding and default widths for the start sequencer
// Contents: state_e (IDLE/LAUNCH/RUN), DEF_DEPTH_LOG2, DEF_TAG_W.
package startseq_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2
  } state_e;
  localparam int DEF_DEPTH_LOG2 = 2;
  localparam int DEF_TAG_W      = 8;
endpackage

// File: rtl/startseq_fifo.sv
// startseq_fifo: tag FIFO with registered pointers and an occupancy count
// Ports: clk_i, rst_i (async, active-high), push_i/data_i write the tail,
//        pop_i advances the head, head_o is the head entry, fill_o is occupancy.
// Pushes when full and pops when empty are ignored.
module startseq_fifo
  import startseq_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int TAG_W      = DEF_TAG_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [TAG_W-1:0]      data_i,
  input  logic                  pop_i,
  output logic [TAG_W-1:0]      head_o,
  output logic [DEPTH_LOG2:0]   fill_o
);
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
  logic [TAG_W-1:0] mem_q [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0] fill_q, fill_d;
  logic push, pop;
  always_comb begin
    push     = push_i && (fill_q != FULL);
    pop      = pop_i && (fill_q != '0);
    wr_ptr_d = push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
    fill_d   = fill_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  // Storage is data only; validity is tracked by the pointers and fill count.
  always_ff @(posedge clk_i)
    if (push) mem_q[wr_ptr_q] <= data_i;
  assign head_o = mem_q[rd_ptr_q];
  assign fill_o = fill_q;
endmodule

// File: rtl/startseq.sv
// startseq: queues tagged jobs and launches them one at a time into the busy counter
// Ports: i_clk, i_reset (async, active-high); i_req_valid/o_req_ready/i_req_tag
//        request handshake; o_start one-cycle launch pulse; i_busy from the
//        busy counter; o_active/o_tag current job; o_done/o_done_tag completion
//        pulse; o_fill FIFO occupancy.
// Build option: STARTSEQ_B2B_EN lets RUN hand over straight to LAUNCH when
// another job is queued, so done and the next start share a cycle.
module startseq
  import startseq_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int TAG_W      = DEF_TAG_W
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [TAG_W-1:0]      i_req_tag,
  output logic                  o_start,
  input  logic                  i_busy,
  output logic                  o_active,
  output logic [TAG_W-1:0]      o_tag,
  output logic                  o_done,
  output logic [TAG_W-1:0]      o_done_tag,
  output logic [DEPTH_LOG2:0]   o_fill
);
`ifdef STARTSEQ_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
  state_e state_q, state_d;
  logic start_q, start_d, active_q, active_d, done_q, done_d;
  logic [TAG_W-1:0] tag_q, tag_d, done_tag_q, done_tag_d, head;
  logic push, pop, nonempty;
  assign o_req_ready = o_fill != FULL;
  assign push        = i_req_valid && o_req_ready;
  assign pop         = state_q == LAUNCH;
  assign nonempty    = o_fill != '0;
  startseq_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .TAG_W      (TAG_W)
  ) u_fifo (
    .clk_i  (i_clk),
    .rst_i  (i_reset),
    .push_i (push),
    .data_i (i_req_tag),
    .pop_i  (pop),
    .head_o (head),
    .fill_o (o_fill)
  );
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:    state_d = (nonempty && !i_busy) ? LAUNCH : IDLE;
      LAUNCH:  state_d = RUN;
      RUN: begin
        done_d  = !i_busy;
        state_d = i_busy ? RUN : (B2B && nonempty) ? LAUNCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // o_start is registered, so it is high exactly while the FSM sits in LAUNCH.
    start_d    = state_d == LAUNCH;
    tag_d      = pop ? head : tag_q;
    active_d   = pop ? 1'b1 : done_d ? 1'b0 : active_q;
    done_tag_d = done_d ? tag_q : done_tag_q;
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      tag_q      <= '0;
      done_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      active_q   <= active_d;
      done_q     <= done_d;
      tag_q      <= tag_d;
      done_tag_q <= done_tag_d;
    end
  assign o_start    = start_q;
  assign o_active   = active_q;
  assign o_tag      = tag_q;
  assign o_done     = done_q;
  assign o_done_tag = done_tag_q;
endmodule

// File: tb/tb_startseq.sv
// tb_startseq: scoreboard bench for startseq with a modelled downstream busy counter
module tb_startseq;
  localparam int DL = 2;
  localparam int TW = 8;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, force_busy = 1'b0, busy;
  logic [TW-1:0] req_tag = '0;
  logic o_req_ready, o_start, o_active, o_done;
  logic [TW-1:0] o_tag, o_done_tag;
  logic [DL:0] o_fill;
  int n_cmp = 0, n_bad = 0, cyc = 0, n_start = 0, n_done = 0, n_coinc = 0;
  int start_cyc = 0, done_cyc = -100, gap = 0, len = 22;
  logic busy_seen = 1'b0;
  logic [TW-1:0] coinc_tag = '0;
  logic [7:0] cnt;
  logic [TW-1:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Busy counter model: busy for len-1 cycles starting the cycle after o_start.
  always @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (o_start) cnt <= 8'(len - 1);
    else if (cnt != 0) cnt <= cnt - 8'd1;
  assign busy = force_busy || (cnt != 0);

  startseq #(.DEPTH_LOG2(DL), .TAG_W(TW)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_req_valid (req_valid),
    .o_req_ready (o_req_ready),
    .i_req_tag   (req_tag),
    .o_start     (o_start),
    .i_busy      (busy),
    .o_active    (o_active),
    .o_tag       (o_tag),
    .o_done      (o_done),
    .o_done_tag  (o_done_tag),
    .o_fill      (o_fill)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [TW-1:0] e;
    if (busy) busy_seen = 1'b1;
    if (o_done) begin
      n_done++;
      done_cyc = cyc;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = 'x;
      chk("done_tag", {24'h0, o_done_tag}, {24'h0, e});
    end
    if (o_start) begin
      n_start++;
      start_cyc = cyc;
      gap = cyc - done_cyc;
      if (o_done) begin
        n_coinc++;
        coinc_tag = o_done_tag;
      end
    end
  end

  task automatic send(input logic [TW-1:0] t);
    req_valid = 1'b1;
    req_tag   = t;
    for (int k = 0; k < 200 && !o_req_ready; k++) @(negedge clk);
    chk("send_ready", {31'h0, o_req_ready}, 32'h1);
    if (o_req_ready) exp_q.push_back(t);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int k = 0; k < budget && n_done < target; k++) @(negedge clk);
    chk("wait_done", n_done, target);
  endtask

  task automatic wait_active();
    for (int k = 0; k < 20 && !o_active; k++) @(negedge clk);
    chk("wait_active", {31'h0, o_active}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int t0, s0, d0, c0;
    repeat (3) @(negedge clk);
    chk("rst_start", {31'h0, o_start}, 0);
    chk("rst_active", {31'h0, o_active}, 0);
    chk("rst_tag", {24'h0, o_tag}, 0);
    chk("rst_done", {31'h0, o_done}, 0);
    chk("rst_done_tag", {24'h0, o_done_tag}, 0);
    chk("rst_fill", {29'h0, o_fill}, 0);
    chk("rst_ready", {31'h0, o_req_ready}, 1);
    rst = 1'b0;
    @(negedge clk);

    // single job
    t0 = cyc; s0 = n_start; d0 = n_done;
    send(8'h5A);
    wait_done(d0 + 1, 100);
    chk("single_start_lat", start_cyc - t0, 2);
    chk("single_done_lat", done_cyc - start_cyc, 23);
    chk("single_nstart", n_start - s0, 1);
    chk("single_fill", {29'h0, o_fill}, 0);
    repeat (3) @(negedge clk);

    // full FIFO behind a running job
    s0 = n_start; d0 = n_done;
    send(8'h10);
    wait_active();
    for (int i = 1; i <= 4; i++) send(8'(i));
    chk("ff_fill", {29'h0, o_fill}, 4);
    chk("ff_ready", {31'h0, o_req_ready}, 0);
    send(8'h05);
    chk("ff_held_nstart", n_start - s0, 2);
    chk("ff_held_ndone", n_done - d0, 1);
    chk("ff_fill_after5", {29'h0, o_fill}, 4);
    wait_done(d0 + 6, 400);
    chk("ff_drained", {29'h0, o_fill}, 0);
    repeat (3) @(negedge clk);

    // zero-length job
    len = 1; busy_seen = 1'b0; s0 = n_start; d0 = n_done;
    send(8'h33);
    wait_done(d0 + 1, 50);
    chk("zl_lat", done_cyc - start_cyc, 2);
    chk("zl_busy_seen", {31'h0, busy_seen}, 0);
    repeat (5) @(negedge clk);
    chk("zl_active", {31'h0, o_active}, 0);
    chk("zl_nstart", n_start - s0, 1);
    len = 22;

    // busy guard
    force_busy = 1'b1; s0 = n_start; d0 = n_done;
    send(8'h77);
    repeat (10) @(negedge clk);
    chk("bg_nostart", n_start - s0, 0);
    chk("bg_fill", {29'h0, o_fill}, 1);
    t0 = cyc;
    force_busy = 1'b0;
    for (int k = 0; k < 10 && n_start == s0; k++) @(negedge clk);
    chk("bg_lat", start_cyc - t0, 1);
    wait_done(d0 + 1, 100);
    repeat (3) @(negedge clk);

    // reset mid-run with queued tags
    send(8'hA1);
    wait_active();
    send(8'hB1); send(8'hB2); send(8'hB3);
    chk("mr_fill", {29'h0, o_fill}, 3);
    rst = 1'b1;
    #1;
    chk("mr_start", {31'h0, o_start}, 0);
    chk("mr_active", {31'h0, o_active}, 0);
    chk("mr_tag", {24'h0, o_tag}, 0);
    chk("mr_done", {31'h0, o_done}, 0);
    chk("mr_done_tag", {24'h0, o_done_tag}, 0);
    chk("mr_fill0", {29'h0, o_fill}, 0);
    chk("mr_ready", {31'h0, o_req_ready}, 1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    s0 = n_start; d0 = n_done;
    repeat (60) @(negedge clk);
    chk("mr_no_start", n_start - s0, 0);
    chk("mr_no_done", n_done - d0, 0);

    // two queued jobs: handover with or without back-to-back
    c0 = n_coinc; d0 = n_done;
    send(8'hC1);
    send(8'hC2);
    wait_done(d0 + 2, 150);
    chk("pair_tag", {24'h0, o_tag}, 32'hC2);
`ifdef STARTSEQ_B2B_EN
    chk("b2b_coinc", n_coinc - c0, 1);
    chk("b2b_gap", gap, 0);
    chk("b2b_coinc_tag", {24'h0, coinc_tag}, 32'hC1);
`else
    chk("seq_coinc", n_coinc - c0, 0);
    chk("seq_gap", gap, 1);
`endif
    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
